// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: request ops, memory write modes,
// fault codes, FSM state constants and small request-decode helpers.
package mem_access_unit_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [1:0] WM_NONE = 2'd0;
  localparam logic [1:0] WM_BYTE = 2'd1;
  localparam logic [1:0] WM_HALF = 2'd2;
  localparam logic [1:0] WM_WORD = 2'd3;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_MISALIGNED = 3'd1;
  localparam logic [2:0] FC_ACCESS     = 3'd2;
  localparam logic [2:0] FC_TIMEOUT    = 3'd3;
  localparam logic [2:0] FC_ILLEGAL    = 3'd4;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE          = 3'd0;
  localparam state_t ST_READ_WAIT     = 3'd1;
  localparam state_t ST_WRITE_REQ     = 3'd2;
  localparam state_t ST_WRITE_RELEASE = 3'd3;
  localparam state_t ST_RESP          = 3'd4;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // op[1:0] is the access size for every legal op: 0 byte, 1 half, 2 word.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == 2'd1) && addr_lo[0]) || ((size == 2'd2) && (addr_lo != 2'd0));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory bus of the load/store unit.
// Handshake: a request transfers on a clock edge where req_valid & req_ready; every accepted request yields exactly one single-cycle resp_valid pulse.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [2:0]  resp_fault_code;
  logic [31:0] mem_address;
  logic [1:0]  mem_write_mode;
  logic [7:0]  mem_write_byte;
  logic [15:0] mem_write_half_word;
  logic [31:0] mem_write_word;
  logic        mem_error;
  logic        mem_done;
  logic [7:0]  mem_byte;
  logic [15:0] mem_half_word;
  logic [31:0] mem_word;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code,
    output mem_address, mem_write_mode, mem_write_byte, mem_write_half_word, mem_write_word,
    input  mem_error, mem_done, mem_byte, mem_half_word, mem_word
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code,
    input  mem_address, mem_write_mode, mem_write_byte, mem_write_half_word, mem_write_word,
    output mem_error, mem_done, mem_byte, mem_half_word, mem_word
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load data sizing: picks the byte/half/word read field for a
// load op and sign- or zero-extends it to 32 bits.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [7:0]  byte_i,
  input  logic [15:0] half_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    case (op_i)
      OP_LB:   data_o = {{24{byte_i[7]}}, byte_i};
      OP_LBU:  data_o = {24'h0, byte_i};
      OP_LH:   data_o = {{16{half_i[15]}}, half_i};
      OP_LHU:  data_o = {16'h0, half_i};
      OP_LW:   data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator-side load/store unit: turns one pipeline request into one
// data-memory transaction and returns exactly one response per request.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] MEM_LIMIT      = 32'h00020000,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_unit_if.master    bus,
  output logic [2:0]           dbg_state_o
);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [15:0] whalf_q, whalf_d;
  logic [31:0] wword_q, wword_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [2:0]  code_q, code_d;

  logic [31:0] ext_data;
  logic [1:0]  req_size;

  assign req_size = bus.req_op[1:0];

  mem_access_unit_load_extend u_load_extend (
    .op_i   (op_q),
    .byte_i (bus.mem_byte),
    .half_i (bus.mem_half_word),
    .word_i (bus.mem_word),
    .data_o (ext_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    wbyte_d = wbyte_q;
    whalf_d = whalf_q;
    wword_d = wword_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          rdata_d = '0;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          cnt_d   = '0;
          // Rejected requests leave the memory address untouched.
          if (!op_legal(bus.req_op)) begin
            fault_d = 1'b1;
            code_d  = FC_ILLEGAL;
            state_d = ST_RESP;
          end else if (misaligned(req_size, bus.req_addr[1:0])) begin
            fault_d = 1'b1;
            code_d  = FC_MISALIGNED;
            state_d = ST_RESP;
          end else if (!bus.req_op[3] && (bus.req_addr >= MEM_LIMIT)) begin
            fault_d = 1'b1;
            code_d  = FC_ACCESS;
            state_d = ST_RESP;
          end else if (!bus.req_op[3]) begin
            addr_d  = bus.req_addr;
            state_d = ST_READ_WAIT;
          end else begin
            addr_d  = bus.req_addr;
            mode_d  = req_size + 2'd1;
            wbyte_d = (req_size == 2'd0) ? bus.req_wdata[7:0]  : 8'h0;
            whalf_d = (req_size == 2'd1) ? bus.req_wdata[15:0] : 16'h0;
            wword_d = (req_size == 2'd2) ? bus.req_wdata       : 32'h0;
            state_d = ST_WRITE_REQ;
          end
        end
      end
      ST_READ_WAIT: begin
        if (cnt_q == 8'(READ_LATENCY - 1)) begin
          rdata_d = ext_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WRITE_REQ: begin
        // Done is checked first so it wins over a coincident timeout.
        if (bus.mem_done) begin
          mode_d  = WM_NONE;
          wbyte_d = '0;
          whalf_d = '0;
          wword_d = '0;
          cnt_d   = '0;
          if (bus.mem_error) begin
            fault_d = 1'b1;
            code_d  = FC_ACCESS;
          end
          state_d = ST_WRITE_RELEASE;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          mode_d  = WM_NONE;
          wbyte_d = '0;
          whalf_d = '0;
          wword_d = '0;
          fault_d = 1'b1;
          code_d  = FC_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WRITE_RELEASE: begin
        if (!bus.mem_done) begin
          state_d = ST_RESP;
        end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          code_d  = FC_TIMEOUT;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      mode_q  <= WM_NONE;
      wbyte_q <= '0;
      whalf_q <= '0;
      wword_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      wbyte_q <= wbyte_d;
      whalf_q <= whalf_d;
      wword_q <= wword_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  // Response fields are only presented during the single RESP cycle.
  assign bus.req_ready           = (state_q == ST_IDLE);
  assign bus.resp_valid          = (state_q == ST_RESP);
  assign bus.resp_rdata          = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign bus.resp_fault          = (state_q == ST_RESP) ? fault_q : 1'b0;
  assign bus.resp_fault_code     = (state_q == ST_RESP) ? code_q  : FC_NONE;
  assign bus.mem_address         = addr_q;
  assign bus.mem_write_mode      = mode_q;
  assign bus.mem_write_byte      = wbyte_q;
  assign bus.mem_write_half_word = whalf_q;
  assign bus.mem_write_word      = wword_q;
  assign dbg_state_o             = state_q;

endmodule
